// File: rtl/min_sec_counter.sv
// min_sec_counter: MM:SS time-of-day style counter kept as four cascaded BCD
// digits, advanced by a one-cycle 1 Hz tick while run is high.
//
// Ports
//   clk_50mhz            in   system clock, all state changes on rising edge
//   reset                in   asynchronous active-low reset
//   tick_1hz             in   one-cycle advance pulse from the clock divider
//   run                  in   1 = counting enabled, 0 = paused (ticks dropped)
//   clear                in   synchronous clear, highest priority
//   load                 in   synchronous minute preset, below clear
//   load_min_tens/ones   in   BCD minute value used by load
//   sec_ones..min_tens   out  registered BCD time digits
//   wrap_tick            out  one-cycle pulse after the MINUTE_LIMIT:59 -> 00:00 rollover
//   load_err             out  one-cycle pulse after a rejected load
module min_sec_counter #(
  parameter int unsigned MINUTE_LIMIT = 59
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       run,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       wrap_tick,
  output logic       load_err
);

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned VALUE_W  = 8;
  localparam logic [DIGIT_W-1:0] LIM_TENS = DIGIT_W'(MINUTE_LIMIT / 10);
  localparam logic [DIGIT_W-1:0] LIM_ONES = DIGIT_W'(MINUTE_LIMIT % 10);
  localparam logic [VALUE_W-1:0] LIM_VAL  = VALUE_W'(MINUTE_LIMIT);

  // Per-edge action after priority resolution (clear > load > advance).
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_REJECT,
    ACT_ADVANCE
  } action_e;

  logic [DIGIT_W-1:0] sec_ones_q, sec_ones_d;
  logic [DIGIT_W-1:0] sec_tens_q, sec_tens_d;
  logic [DIGIT_W-1:0] min_ones_q, min_ones_d;
  logic [DIGIT_W-1:0] min_tens_q, min_tens_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;

  action_e            action_c;
  logic [VALUE_W-1:0] load_val_c;
  logic               load_ok_c;
  logic               sec_ones_max_c;
  logic               sec_tens_max_c;
  logic               min_max_c;

  // Load validation: both digits BCD and the pair no larger than the limit.
  always_comb begin
    load_val_c = VALUE_W'(load_min_tens) * VALUE_W'(10) + VALUE_W'(load_min_ones);
    load_ok_c  = (load_min_tens <= DIGIT_W'(9)) &&
                 (load_min_ones <= DIGIT_W'(9)) &&
                 (load_val_c <= LIM_VAL);
  end

  // Priority decode of the requests seen on this edge.
  always_comb begin
    action_c = ACT_HOLD;
    if (clear) begin
      action_c = ACT_CLEAR;
    end else if (load) begin
      action_c = load_ok_c ? ACT_LOAD : ACT_REJECT;
    end else if (tick_1hz && run) begin
      action_c = ACT_ADVANCE;
    end
  end

  // Terminal-count detection; ">=" keeps any out-of-range value self-correcting.
  always_comb begin
    sec_ones_max_c = (sec_ones_q >= DIGIT_W'(9));
    sec_tens_max_c = (sec_tens_q >= DIGIT_W'(5));
    min_max_c      = (min_tens_q > LIM_TENS) ||
                     ((min_tens_q == LIM_TENS) && (min_ones_q >= LIM_ONES));
  end

  // Next-state for the digit cascade and the two status pulses.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;

    unique case (action_c)
      ACT_CLEAR: begin
        sec_ones_d = '0;
        sec_tens_d = '0;
        min_ones_d = '0;
        min_tens_d = '0;
      end

      ACT_LOAD: begin
        sec_ones_d = '0;
        sec_tens_d = '0;
        min_ones_d = load_min_ones;
        min_tens_d = load_min_tens;
      end

      ACT_REJECT: begin
        err_d = 1'b1;
      end

      ACT_ADVANCE: begin
        if (!sec_ones_max_c) begin
          sec_ones_d = sec_ones_q + DIGIT_W'(1);
        end else begin
          sec_ones_d = '0;
          if (!sec_tens_max_c) begin
            sec_tens_d = sec_tens_q + DIGIT_W'(1);
          end else begin
            sec_tens_d = '0;
            // Minute pair counts as BCD 00..MINUTE_LIMIT.
            if (min_max_c) begin
              min_ones_d = '0;
              min_tens_d = '0;
              wrap_d     = 1'b1;
            end else if (min_ones_q >= DIGIT_W'(9)) begin
              min_ones_d = '0;
              min_tens_d = min_tens_q + DIGIT_W'(1);
            end else begin
              min_ones_d = min_ones_q + DIGIT_W'(1);
            end
          end
        end
      end

      default: begin
        // ACT_HOLD: everything keeps its value, pulses stay low.
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign wrap_tick = wrap_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_min_sec_counter.sv
// Testbench for min_sec_counter: directed scenarios plus a randomized phase,
// every cycle compared against a seconds-since-00:00 reference model.
module tb_min_sec_counter;

  localparam int unsigned LIMIT  = 59;
  localparam int unsigned PERIOD = (LIMIT + 1) * 60;

  logic       clk_50mhz = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_min_tens = 4'd0;
  logic [3:0] load_min_ones = 4'd0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       wrap_tick, load_err;

  min_sec_counter #(.MINUTE_LIMIT(LIMIT)) dut (
    .clk_50mhz     (clk_50mhz),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .run           (run),
    .clear         (clear),
    .load          (load),
    .load_min_tens (load_min_tens),
    .load_min_ones (load_min_ones),
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .min_ones      (min_ones),
    .min_tens      (min_tens),
    .wrap_tick     (wrap_tick),
    .load_err      (load_err)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Reference model: elapsed seconds since 00:00 plus expected pulses.
  int unsigned t_m;
  bit          exp_wrap;
  bit          exp_err;
  int          vectors;
  int          miscompares;

  function automatic void model_edge();
    int unsigned v;
    exp_wrap = 1'b0;
    exp_err  = 1'b0;
    if (clear) begin
      t_m = 0;
    end else if (load) begin
      v = int'(load_min_tens) * 10 + int'(load_min_ones);
      if (load_min_tens <= 9 && load_min_ones <= 9 && v <= LIMIT) t_m = v * 60;
      else exp_err = 1'b1;
    end else if (tick_1hz && run) begin
      t_m = (t_m + 1) % PERIOD;
      exp_wrap = (t_m == 0);
    end
  endfunction

  task automatic cmp4(input string tag, input logic [3:0] got, input int unsigned want);
    vectors++;
    assert (got === 4'(want)) else begin
      miscompares++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic cmp1(input string tag, input logic got, input bit want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got %0b want %0b", tag, got, want);
    end
  endtask

  // Compare every output against the model.
  task automatic check_model(input string tag);
    int unsigned m, s;
    m = t_m / 60;
    s = t_m % 60;
    cmp4({tag, ".sec_ones"}, sec_ones, s % 10);
    cmp4({tag, ".sec_tens"}, sec_tens, s / 10);
    cmp4({tag, ".min_ones"}, min_ones, m % 10);
    cmp4({tag, ".min_tens"}, min_tens, m / 10);
    cmp1({tag, ".wrap_tick"}, wrap_tick, exp_wrap);
    cmp1({tag, ".load_err"}, load_err, exp_err);
  endtask

  // Compare the displayed time against a literal MM:SS from the scenario.
  task automatic expect_time(input string tag, input int unsigned mm, input int unsigned ss);
    cmp4({tag, ".min_tens"}, min_tens, mm / 10);
    cmp4({tag, ".min_ones"}, min_ones, mm % 10);
    cmp4({tag, ".sec_tens"}, sec_tens, ss / 10);
    cmp4({tag, ".sec_ones"}, sec_ones, ss % 10);
  endtask

  // One clock edge: update the model, sample 1 time unit after the edge.
  task automatic cyc(input string tag);
    @(posedge clk_50mhz);
    if (!reset) begin
      t_m = 0; exp_wrap = 1'b0; exp_err = 1'b0;
    end else begin
      model_edge();
    end
    #1;
    check_model(tag);
  endtask

  task automatic tick_then_idle(input string tag, input int idle);
    tick_1hz = 1'b1;
    cyc(tag);
    tick_1hz = 1'b0;
    repeat (idle) cyc(tag);
  endtask

  task automatic do_load(input string tag, input logic [3:0] tens, input logic [3:0] ones);
    load = 1'b1; load_min_tens = tens; load_min_ones = ones;
    cyc(tag);
    load = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    t_m = 0; exp_wrap = 1'b0; exp_err = 1'b0;

    // Reset state, visible without any clock edge.
    #1;
    check_model("reset_async");
    expect_time("reset_state", 0, 0);
    repeat (2) cyc("reset_hold");
    reset = 1'b1;

    // Counting: 65 ticks spaced 5 cycles apart -> 01:05.
    run = 1'b1;
    repeat (65) tick_then_idle("count", 4);
    expect_time("count_65", 1, 5);
    cmp1("count_no_wrap", wrap_tick, 1'b0);

    // Rollover from 59:59.
    do_load("ro_load", 4'd5, 4'd9);
    expect_time("ro_loaded", 59, 0);
    repeat (59) tick_then_idle("ro", 1);
    expect_time("ro_5959", 59, 59);
    tick_1hz = 1'b1;
    cyc("ro_edge");
    tick_1hz = 1'b0;
    expect_time("ro_wrapped", 0, 0);
    cmp1("ro_wrap_high", wrap_tick, 1'b1);
    cyc("ro_after");
    cmp1("ro_wrap_low", wrap_tick, 1'b0);

    // Pausing: ticks while run=0 are dropped.
    clear = 1'b1; cyc("pause_clr"); clear = 1'b0;
    repeat (10) tick_then_idle("pause_pre", 1);
    expect_time("pause_at10", 0, 10);
    run = 1'b0;
    repeat (3) tick_then_idle("paused", 2);
    expect_time("paused_hold", 0, 10);
    run = 1'b1;
    tick_then_idle("resume", 1);
    expect_time("resume_11", 0, 11);

    // Simultaneous events: clear/load beat a coincident tick.
    clear = 1'b1; cyc("sim_clr0"); clear = 1'b0;
    repeat (42) tick_then_idle("sim_pre", 1);
    expect_time("sim_at42", 0, 42);
    clear = 1'b1; tick_1hz = 1'b1;
    cyc("sim_clr");
    clear = 1'b0; tick_1hz = 1'b0;
    expect_time("sim_clr_tick", 0, 0);
    load = 1'b1; load_min_tens = 4'd2; load_min_ones = 4'd3; tick_1hz = 1'b1;
    cyc("sim_load");
    load = 1'b0; tick_1hz = 1'b0;
    expect_time("sim_load_tick", 23, 0);

    // Load rejection: out of range value and non-BCD digit.
    do_load("rej_60", 4'd6, 4'd0);
    expect_time("rej_60_hold", 23, 0);
    cmp1("rej_60_err", load_err, 1'b1);
    cyc("rej_60_after");
    cmp1("rej_60_err_low", load_err, 1'b0);
    do_load("rej_0a", 4'd0, 4'hA);
    expect_time("rej_0a_hold", 23, 0);
    cmp1("rej_0a_err", load_err, 1'b1);
    cyc("rej_0a_after");
    cmp1("rej_0a_err_low", load_err, 1'b0);

    // Holding load keeps reloading and suppresses ticks.
    load = 1'b1; load_min_tens = 4'd0; load_min_ones = 4'd7; tick_1hz = 1'b1;
    repeat (4) cyc("load_hold");
    load = 1'b0; tick_1hz = 1'b0;
    expect_time("load_hold_07", 7, 0);

    // Asynchronous reset at 12:34, observed before the next edge.
    do_load("ar_load", 4'd1, 4'd2);
    repeat (34) tick_then_idle("ar_pre", 1);
    expect_time("ar_1234", 12, 34);
    #4 reset = 1'b0;
    t_m = 0; exp_wrap = 1'b0; exp_err = 1'b0;
    #1;
    expect_time("ar_async", 0, 0);
    check_model("ar_async_all");
    #4 reset = 1'b1;
    tick_then_idle("ar_tick", 1);
    expect_time("ar_resume", 0, 1);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom % 600) != 0;
      clear    = ($urandom % 150) == 0;
      load     = ($urandom % 90) == 0;
      load_min_tens = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 6);
      load_min_ones = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
      tick_1hz = ($urandom % 3) == 0;
      run      = ($urandom % 5) != 0;
      if (!reset) begin
        t_m = 0; exp_wrap = 1'b0; exp_err = 1'b0;
      end
      cyc("rand");
    end
    reset = 1'b1; clear = 1'b0; load = 1'b0; tick_1hz = 1'b0;
    cyc("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
